// File: rtl/alm_pkg.sv
// Shared types and constants for the approximate log-domain divider.
// Payload fields are sized for the widest supported operand (16 bits).
package alm_pkg;

    localparam int unsigned MAX_WIDTH = 16;
    // Fraction fields hold the truncated fraction MSB-aligned, zero below the kept bits
    localparam int unsigned FW = MAX_WIDTH - 1;

    typedef logic [3:0]        k_t;
    typedef logic [FW-1:0]     frac_t;
    typedef logic signed [5:0] e_t;

    typedef struct packed {
        logic s_a;
        logic s_b;
        logic s_q;
        logic z_a;
        logic z_b;
    } flags_t;

    typedef struct packed {
        flags_t f;
        k_t     k_a;
        k_t     k_b;
        frac_t  x_a;
        frac_t  x_b;
    } s1_t;

    typedef struct packed {
        flags_t f;
        e_t     e;
        frac_t  d;
    } s2_t;

    // Magnitude returned for a nonzero dividend over a zero divisor
    function automatic int unsigned dz_sat(int unsigned width, int unsigned frac_bits);
        return (32'd1 << (width + frac_bits)) - 32'd1;
    endfunction

endpackage

// File: rtl/alm_lod_norm.sv
// Leading-one detector plus normalizer: returns the leading-one position and the
// KEEP_WIDTH fraction bits just below it, MSB-aligned in a frac_t.
module alm_lod_norm
    import alm_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned KEEP_WIDTH = 5
) (
    input  logic [WIDTH-1:0] mag,
    output k_t               k,
    output frac_t            frac
);

    logic [WIDTH-1:0] norm;

    always_comb begin
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mag[i]) k = k_t'(i);
        end
        norm = mag << (int'(WIDTH) - 1 - int'(k));
        frac = '0;
        frac[FW-1 -: KEEP_WIDTH] = norm[WIDTH-2 -: KEEP_WIDTH];
    end

    logic unused_norm;
    assign unused_norm = ^norm;

endmodule

// File: rtl/alm_log_divider.sv
// Three-stage Mitchell-style approximate signed divider with valid/ready handshake.
// Define ALM_DIV_COMP_EN to subtract a small bias from the fraction difference.
module alm_log_divider
    import alm_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned KEEP_WIDTH = 5,
    parameter int unsigned FRAC_BITS  = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic signed [WIDTH-1:0]        i_a,
    input  logic signed [WIDTH-1:0]        i_b,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic signed [WIDTH+FRAC_BITS:0] o_q,
    output logic                           o_dz
);

    localparam int unsigned QW = WIDTH + FRAC_BITS + 1;
    localparam logic [QW-1:0] SAT = QW'(dz_sat(WIDTH, FRAC_BITS));

    logic v1_q, v2_q, v3_q;
    logic adv, accept;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic [QW-1:0] q_d;
    logic          dz_d;

    assign adv     = ~v3_q | i_ready;
    assign accept  = i_valid & adv;
    assign o_ready = adv;
    assign o_valid = v3_q;

    // S1: WIDTH-bit unsigned magnitude is exact even for the most negative operand
    logic [WIDTH-1:0] mag_a, mag_b;
    k_t               k_a, k_b;
    frac_t            x_a, x_b;

    assign mag_a = i_a[WIDTH-1] ? -i_a : i_a;
    assign mag_b = i_b[WIDTH-1] ? -i_b : i_b;

    alm_lod_norm #(.WIDTH(WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) u_lod_a (
        .mag  (mag_a),
        .k    (k_a),
        .frac (x_a)
    );

    alm_lod_norm #(.WIDTH(WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) u_lod_b (
        .mag  (mag_b),
        .k    (k_b),
        .frac (x_b)
    );

    always_comb begin
        s1_d.f.s_a = i_a[WIDTH-1];
        s1_d.f.s_b = i_b[WIDTH-1];
        s1_d.f.s_q = i_a[WIDTH-1] ^ i_b[WIDTH-1];
        s1_d.f.z_a = (i_a == '0);
        s1_d.f.z_b = (i_b == '0);
        s1_d.k_a   = k_a;
        s1_d.k_b   = k_b;
        s1_d.x_a   = x_a;
        s1_d.x_b   = x_b;
    end

    // S2: fraction difference; dropping the borrow bit is the +2^KEEP_WIDTH fix-up
    logic [KEEP_WIDTH:0]   diff;
    logic                  borrow;
    logic [KEEP_WIDTH-1:0] d_fix;

`ifdef ALM_DIV_COMP_EN
    localparam logic [KEEP_WIDTH-1:0] COMP = KEEP_WIDTH'(1 << (KEEP_WIDTH - 4));
`endif

    always_comb begin
        diff   = {1'b0, s1_q.x_a[FW-1 -: KEEP_WIDTH]} - {1'b0, s1_q.x_b[FW-1 -: KEEP_WIDTH]};
        borrow = diff[KEEP_WIDTH];
        d_fix  = diff[KEEP_WIDTH-1:0];
`ifdef ALM_DIV_COMP_EN
        d_fix  = (d_fix >= COMP) ? d_fix - COMP : '0;
`endif
        s2_d.f = s1_q.f;
        s2_d.e = e_t'(int'(s1_q.k_a) - int'(s1_q.k_b) - int'(borrow));
        s2_d.d = '0;
        s2_d.d[FW-1 -: KEEP_WIDTH] = d_fix;
    end

    // S3: antilog by shifting the implicit-one mantissa, then sign and zero rules
    logic [QW-1:0] m_ext, mag_q;
    int            sh;

    always_comb begin
        m_ext = QW'({1'b1, s2_q.d[FW-1 -: KEEP_WIDTH]});
        sh    = int'($signed(s2_q.e)) + int'(FRAC_BITS) - int'(KEEP_WIDTH);
        mag_q = (sh >= 0) ? (m_ext << sh) : (m_ext >> (-sh));
        q_d   = s2_q.f.s_q ? -mag_q : mag_q;
        dz_d  = s2_q.f.z_b;
        if (s2_q.f.z_b) begin
            if (s2_q.f.z_a)      q_d = '0;
            else if (s2_q.f.s_a) q_d = -SAT;
            else                 q_d = SAT;
        end else if (s2_q.f.z_a) begin
            q_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            o_q  <= '0;
            o_dz <= 1'b0;
        end else if (adv) begin
            v1_q <= i_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (accept) s1_q <= s1_d;
            if (v1_q)   s2_q <= s2_d;
            if (v2_q) begin
                o_q  <= q_d;
                o_dz <= dz_d;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s1_q, s2_q};

endmodule

// File: tb/tb_alm_log_divider.sv
// Directed-vector bench for alm_log_divider (WIDTH=16, KEEP_WIDTH=5, FRAC_BITS=8).
module tb_alm_log_divider;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               out_ready;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic               out_valid;
    logic               in_ready;
    logic signed [24:0] q;
    logic               dz;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ALM_DIV_COMP_EN
    localparam int Q100_10 = 2560;
    localparam int Q10_100 = 26;
`else
    localparam int Q100_10 = 2688;
    localparam int Q10_100 = 27;
`endif
    localparam int QSAT = 16777215;

    alm_log_divider #(.WIDTH(16), .KEEP_WIDTH(5), .FRAC_BITS(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (in_valid),
        .o_ready (out_ready),
        .i_a     (a),
        .i_b     (b),
        .o_valid (out_valid),
        .i_ready (in_ready),
        .o_q     (q),
        .o_dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input int ta, input int tb,
                           input int exp_q, input int exp_dz);
        int cyc;
        in_ready = 1'b1;
        a        = 16'(ta);
        b        = 16'(tb);
        in_valid = 1'b1;
        #1;
        check({tag, "_ready"}, out_ready, 1);
        step();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 8) begin
            step();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 3);
        check({tag, "_q"}, q, exp_q);
        check({tag, "_dz"}, dz, exp_dz);
        step();
    endtask

    int ta[4];
    int tb[4];
    int tq[4];
    int tdz[4];

    initial begin
        int sent, got, held, seen;
        logic acc;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_ready = 1'b1;
        a        = '0;
        b        = '0;
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_q", q, 0);
        check("rst_dz", dz, 0);
        check("rst_ready", out_ready, 1);
        step();

        run_one("p100_10", 100, 10, Q100_10, 0);
        run_one("borrow", 10, 100, Q10_100, 0);
        run_one("neg_a", -100, 10, -Q100_10, 0);
        run_one("neg_both", -100, -10, Q100_10, 0);
        run_one("min_neg", -32768, 1, -8388608, 0);
        run_one("dz_pos", 7, 0, QSAT, 1);
        run_one("dz_neg", -7, 0, -QSAT, 1);
        run_one("zero_a", 0, 5, 0, 0);
        run_one("zero_zero", 0, 0, 0, 1);

        // Backpressure: hold the first result for 5 cycles with the 4th pair waiting
        ta  = '{100, 10, -100, 7};
        tb  = '{10, 100, 10, 0};
        tq  = '{Q100_10, Q10_100, -Q100_10, QSAT};
        tdz = '{0, 0, 0, 1};
        sent = 0;
        got  = 0;
        held = 0;
        for (int it = 0; it < 40 && got < 4; it++) begin
            in_ready = (held >= 5);
            if (sent < 4) begin
                in_valid = 1'b1;
                a        = 16'(ta[sent]);
                b        = 16'(tb[sent]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !in_ready) begin
                check("bp_ready_low", out_ready, 0);
                check("bp_q_stable", q, tq[0]);
                held++;
            end
            if (out_valid && in_ready) begin
                check($sformatf("bp_q%0d", got), q, tq[got]);
                check($sformatf("bp_dz%0d", got), dz, tdz[got]);
                got++;
            end
            acc = in_valid && out_ready;
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check("bp_count", got, 4);
        check("bp_held", held, 5);
        check("bp_no_dup", out_valid, 0);

        // Reset with three operations in flight
        in_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'(ta[i]);
            b        = 16'(tb[i]);
            step();
        end
        in_valid = 1'b0;
        check("mid_inflight", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_q", q, 0);
        check("mid_rst_dz", dz, 0);
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        check("mid_ready", out_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("mid_nothing_out", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alm_log_divider.md
# alm_log_divider

Pipelined approximate signed divider built on Mitchell-style logarithmic arithmetic with dynamic significand truncation. It is the inverse operation of the team's dynamic-range log multiplier: fraction subtraction replaces fraction addition, and exponent difference replaces exponent sum. It sits beside the multiplier in the approximate-arithmetic datapath and accepts operand pairs over a valid/ready handshake. It returns a signed fixed-point quotient plus a divide-by-zero flag, three cycles later.

## Interface
- `WIDTH`, 16: operand width, two's complement; 8 or 16 supported.
- `KEEP_WIDTH`, 5: truncated fraction bits kept per operand (t); must be ≥4 and ≤ WIDTH-1.
- `FRAC_BITS`, 8: fractional bits of the output quotient.
- `i_clk` input 1: clock, rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_valid` input 1: operand pair valid.
- `o_ready` output 1: block accepts operands this cycle.
- `i_a` input WIDTH signed: dividend.
- `i_b` input WIDTH signed: divisor.
- `o_valid` output 1: result valid.
- `i_ready` input 1: downstream accepts result.
- `o_q` output WIDTH+FRAC_BITS+1 signed: quotient; unit is 2^-FRAC_BITS.
- `o_dz` output 1: divisor was zero; qualified by `o_valid`.

## Operation
- **S1 (capture, on accept):**
  - Register signs s_a and s_b, and s_q = s_a^s_b.
  - Register zero flags z_a and z_b.
  - Take magnitudes |a| and |b|, widened so that |−2^(WIDTH-1)| is representable.
  - Leading-one positions k_a and k_b.
  - Left-normalize each magnitude so its leading one sits at bit WIDTH-1.
  - Truncated fraction x = the KEEP_WIDTH bits immediately below the leading one, MSB-aligned. Zero-fill applies when fewer bits exist.
- **S2 (subtract):**
  - d = x_a − x_b computed on KEEP_WIDTH+1 bits.
  - borrow = d < 0. When borrow, d += 2^KEEP_WIDTH.
  - E = k_a − k_b − borrow, signed, range −WIDTH … WIDTH-1.
  - Compensation is applied here (see Configuration).
- **S3 (antilog):**
  - m = {1, d[KEEP_WIDTH-1:0]}.
  - sh = E + FRAC_BITS − KEEP_WIDTH. Shift m left by sh when sh ≥ 0, otherwise right by −sh; right shifts truncate.
  - Negate the result when s_q is set.
- **Zero rules, applied in S3:**
  - z_b=1, z_a=0: o_dz=1. o_q = +(2^(WIDTH+FRAC_BITS)−1) when s_a=0, otherwise −(2^(WIDTH+FRAC_BITS)−1).
  - z_b=1, z_a=1: o_dz=1, o_q=0.
  - z_a=1, z_b=0: o_dz=0, o_q=0.
- The most negative operand (−2^(WIDTH-1)) is handled exactly; its magnitude is 2^(WIDTH-1).

## Timing
- **Pipeline:** three register stages; each stage has a valid bit.
  - Global advance: adv = ~v3 | i_ready.
  - o_ready = adv, combinational from v3 and i_ready only; it never depends on i_valid.
  - Accept occurs when i_valid & o_ready.
- **Latency:** 3 cycles from accept to o_valid when unstalled. Throughput is one result per cycle.
- **Stall:** when o_valid=1 and i_ready=0, all stages hold and o_q/o_dz stay stable. No result is dropped or duplicated.
- **Bubbles:** the pipeline does not compress bubbles. Empty stages also advance only on adv.
- **Reset:**
  - All valid bits clear immediately; in-flight operations are discarded.
  - o_valid=0, o_q=0, o_dz=0.
  - o_ready=1 from the first cycle after reset is released.
- **Simultaneous output and input:** when i_ready=1 and i_valid=1 in the same cycle, the S3 result retires and the new pair enters S1 in that edge.

## Configuration
- Macro: `ALM_DIV_COMP_EN`.
- **Defined:** after the borrow fix-up, S2 subtracts 2^(KEEP_WIDTH-4) from d, flooring at 0, with no change to E. This offsets Mitchell-division overestimation.
- **Undefined:** d is used uncompensated.
- Zero rules and timing are identical with and without the macro.

## Structure
- Shared package `alm_pkg` holds:
  - The stage-payload struct typedefs: sign/zero flags, k values, fractions, and E.
  - The divide-by-zero saturation-constant function of WIDTH/FRAC_BITS.
- One sub-module, `alm_lod_norm`: a WIDTH-bit leading-one detector plus normalizer that returns k and the truncated fraction. It is instantiated twice in S1.
- The pipeline registers and handshake logic live in the top module.

## Test plan
All scenarios use WIDTH=16, KEEP_WIDTH=5, FRAC_BITS=8, with `ALM_DIV_COMP_EN` undefined unless stated.
1. a=100, b=10 → o_q=2688 (10.5), o_dz=0, o_valid exactly 3 cycles after accept. With the macro defined → 2560.
2. Borrow path: a=10, b=100 → o_q=27.
3. Signs: a=−100, b=10 → −2688; a=−100, b=−10 → 2688; a=−32768, b=1 → −8388608.
4. Zeros:
   - a=7, b=0 → o_dz=1, o_q=16777215.
   - a=−7, b=0 → o_dz=1, o_q=−16777215.
   - a=0, b=5 → o_q=0, o_dz=0.
5. Backpressure: issue 4 back-to-back pairs, hold i_ready=0 for 5 cycles, then release → o_ready drops while the output is held, o_q is stable throughout, and all 4 results emerge in order with no loss.
6. Reset mid-flight: assert i_rst_n=0 with 3 results in flight → o_valid=0 and o_q=0 immediately, and nothing emerges after reset is released.
